// File: rtl/pkg_tpu.sv
// rtl/pkg_tpu.sv - shared TPU scalar-unit types and commit source indices
package pkg_tpu;

    typedef logic [7:0] issue_no_t;

    localparam int N_COMMIT_SRC      = 3;
    localparam int COMMIT_SRC_LDST1  = 0;
    localparam int COMMIT_SRC_LDST2  = 1;
    localparam int COMMIT_SRC_MATH   = 2;

endpackage

// File: rtl/commit_arbiter_s_rr_arbiter.sv
// rtl/commit_arbiter_s_rr_arbiter.sv - parameterised round-robin picker
module rr_arbiter #(
    parameter int N = 3,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [N-1:0] grant,
    output logic [W-1:0] idx
);

    // Search last+1, last+2, ... modulo N and take the first requester.
    always_comb begin : pick
        logic found;
        int   j;
        found = 1'b0;
        j     = 0;
        grant = '0;
        idx   = '0;
        for (int k = 1; k <= N; k++) begin
            j = int'(last) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = W'(j);
            end
        end
    end

endmodule

// File: rtl/commit_arbiter_s.sv
// rtl/commit_arbiter_s.sv - scalar commit arbiter; optional statistics under COMMIT_ARB_STAT_EN
module commit_arbiter_s
    import pkg_tpu::*;
#(
    parameter int N_SRC     = N_COMMIT_SRC,
    parameter int WIDTH_SRC = $clog2(N_SRC)
`ifdef COMMIT_ARB_STAT_EN
    ,
    parameter int WIDTH_CNT = 16
`endif
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [N_SRC-1:0]           I_Req,
    input  issue_no_t [N_SRC-1:0]      I_No,
    output logic [N_SRC-1:0]           O_Busy,
    output logic                       O_Commit_Valid,
    output issue_no_t                  O_Commit_No,
    output logic [WIDTH_SRC-1:0]       O_Commit_Src,
    input  logic                       I_Commit_Ack,
    output logic [N_SRC-1:0]           O_Committed,
    output logic                       O_Err
`ifdef COMMIT_ARB_STAT_EN
    ,
    output logic [N_SRC-1:0][WIDTH_CNT-1:0] O_Grant_Cnt,
    output logic [WIDTH_CNT-1:0]            O_Stall_Cnt
`endif
);

    logic [N_SRC-1:0]      pend;
    issue_no_t [N_SRC-1:0] no_q;
    logic [WIDTH_SRC-1:0]  last;
    logic                  lock;
    logic [WIDTH_SRC-1:0]  lock_src;

    logic [N_SRC-1:0]      arb_grant;
    logic [WIDTH_SRC-1:0]  arb_idx;
    logic [N_SRC-1:0]      win_oh;
    logic [WIDTH_SRC-1:0]  win_idx;
    logic                  valid;
    logic                  fire;

    rr_arbiter #(
        .N (N_SRC),
        .W (WIDTH_SRC)
    ) u_rr (
        .req   (pend),
        .last  (last),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    // A presented-but-unacknowledged entry is frozen so a newly captured
    // higher-priority source cannot steal the slot mid-handshake.
    always_comb begin
        win_idx = lock ? lock_src : arb_idx;
        win_oh  = lock ? (N_SRC'(1) << lock_src) : arb_grant;
        valid   = |pend;
        fire    = valid & I_Commit_Ack;
    end

    // Outputs presented to the reorder buffer are zero when idle.
    always_comb begin
        O_Busy         = pend;
        O_Commit_Valid = valid;
        O_Commit_No    = valid ? no_q[win_idx] : '0;
        O_Commit_Src   = valid ? win_idx : '0;
    end

    // Holding slots, round-robin pointer, lock, committed pulse and sticky error.
    always_ff @(posedge clock) begin
        if (reset) begin
            pend        <= '0;
            no_q        <= '0;
            last        <= WIDTH_SRC'(N_SRC - 1);
            lock        <= 1'b0;
            lock_src    <= '0;
            O_Committed <= '0;
            O_Err       <= 1'b0;
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                if (fire && win_oh[i]) begin
                    pend[i] <= 1'b0;
                end else if (I_Req[i] && !pend[i]) begin
                    pend[i] <= 1'b1;
                    no_q[i] <= I_No[i];
                end
            end
            if (|(I_Req & pend)) begin
                O_Err <= 1'b1;
            end
            if (fire) begin
                last <= win_idx;
            end
            lock        <= valid & ~I_Commit_Ack;
            lock_src    <= win_idx;
            O_Committed <= fire ? win_oh : '0;
        end
    end

`ifdef COMMIT_ARB_STAT_EN
    // Saturating per-source grant counters and a shared stall counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            O_Grant_Cnt <= '0;
            O_Stall_Cnt <= '0;
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                if (fire && win_oh[i] && (O_Grant_Cnt[i] != '1)) begin
                    O_Grant_Cnt[i] <= O_Grant_Cnt[i] + 1'b1;
                end
            end
            if (valid && !I_Commit_Ack && (O_Stall_Cnt != '1)) begin
                O_Stall_Cnt <= O_Stall_Cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_commit_arbiter_s.sv
// tb/tb_commit_arbiter_s.sv - directed self-checking bench for commit_arbiter_s
module tb_commit_arbiter_s;
    import pkg_tpu::*;

    logic             clock = 1'b0;
    logic             reset;
    logic [2:0]       req;
    issue_no_t [2:0]  in_no;
    logic [2:0]       busy;
    logic             valid;
    issue_no_t        cno;
    logic [1:0]       csrc;
    logic             ack;
    logic [2:0]       committed;
    logic             err;
`ifdef COMMIT_ARB_STAT_EN
    logic [2:0][15:0] grant_cnt;
    logic [15:0]      stall_cnt;
`endif

    int n_cmp = 0;
    int n_mis = 0;

    commit_arbiter_s dut (
        .clock          (clock),
        .reset          (reset),
        .I_Req          (req),
        .I_No           (in_no),
        .O_Busy         (busy),
        .O_Commit_Valid (valid),
        .O_Commit_No    (cno),
        .O_Commit_Src   (csrc),
        .I_Commit_Ack   (ack),
        .O_Committed    (committed),
        .O_Err          (err)
`ifdef COMMIT_ARB_STAT_EN
        ,
        .O_Grant_Cnt    (grant_cnt),
        .O_Stall_Cnt    (stall_cnt)
`endif
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; req = '0; ack = 1'b0; in_no = '0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (busy !== 3'b000) begin n_mis++; $display("FAIL rst_busy got %b exp 000", busy); end
        n_cmp++; if (valid !== 1'b0) begin n_mis++; $display("FAIL rst_valid got %b exp 0", valid); end
        n_cmp++; if (cno !== 8'd0) begin n_mis++; $display("FAIL rst_no got %0d exp 0", cno); end
        n_cmp++; if (csrc !== 2'd0) begin n_mis++; $display("FAIL rst_src got %0d exp 0", csrc); end
        n_cmp++; if (committed !== 3'b000) begin n_mis++; $display("FAIL rst_committed got %b exp 000", committed); end
        n_cmp++; if (err !== 1'b0) begin n_mis++; $display("FAIL rst_err got %b exp 0", err); end
        ack = 1'b1;
        tick(); tick();
        n_cmp++; if (committed !== 3'b000) begin n_mis++; $display("FAIL idle_ack_committed got %b exp 000", committed); end
        n_cmp++; if (valid !== 1'b0) begin n_mis++; $display("FAIL idle_ack_valid got %b exp 0", valid); end
    endtask

    task automatic test_single();
        do_reset();
        ack = 1'b1; req = 3'b001; in_no[0] = 8'd5;
        tick();
        req = '0;
        n_cmp++; if (valid !== 1'b1) begin n_mis++; $display("FAIL single_valid got %b exp 1", valid); end
        n_cmp++; if (cno !== 8'd5) begin n_mis++; $display("FAIL single_no got %0d exp 5", cno); end
        n_cmp++; if (csrc !== 2'd0) begin n_mis++; $display("FAIL single_src got %0d exp 0", csrc); end
        n_cmp++; if (busy !== 3'b001) begin n_mis++; $display("FAIL single_busy1 got %b exp 001", busy); end
        n_cmp++; if (committed !== 3'b000) begin n_mis++; $display("FAIL single_nopulse got %b exp 000", committed); end
        tick();
        n_cmp++; if (committed !== 3'b001) begin n_mis++; $display("FAIL single_pulse got %b exp 001", committed); end
        n_cmp++; if (busy !== 3'b000) begin n_mis++; $display("FAIL single_busy2 got %b exp 000", busy); end
        n_cmp++; if (valid !== 1'b0) begin n_mis++; $display("FAIL single_valid2 got %b exp 0", valid); end
        tick();
        n_cmp++; if (committed !== 3'b000) begin n_mis++; $display("FAIL single_pulse_end got %b exp 000", committed); end
    endtask

    task automatic run_rotation(input string tag);
        logic [2:0] exp_pulse [4];
        exp_pulse[0] = 3'b000; exp_pulse[1] = 3'b001; exp_pulse[2] = 3'b010; exp_pulse[3] = 3'b100;
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (cno !== issue_no_t'(10 + k)) begin n_mis++; $display("FAIL %s_no%0d got %0d exp %0d", tag, k, cno, 10 + k); end
            n_cmp++; if (csrc !== 2'(k)) begin n_mis++; $display("FAIL %s_src%0d got %0d exp %0d", tag, k, csrc, k); end
            n_cmp++; if (committed !== exp_pulse[k]) begin n_mis++; $display("FAIL %s_pulse%0d got %b exp %b", tag, k, committed, exp_pulse[k]); end
            tick();
        end
        n_cmp++; if (committed !== exp_pulse[3]) begin n_mis++; $display("FAIL %s_pulse3 got %b exp %b", tag, committed, exp_pulse[3]); end
        n_cmp++; if (valid !== 1'b0) begin n_mis++; $display("FAIL %s_idle got %b exp 0", tag, valid); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        ack = 1'b1; req = 3'b111;
        in_no[0] = 8'd10; in_no[1] = 8'd11; in_no[2] = 8'd12;
        tick();
        req = '0;
        run_rotation("b2b");
    endtask

    task automatic test_stall();
        do_reset();
        ack = 1'b0; req = 3'b111;
        in_no[0] = 8'd10; in_no[1] = 8'd11; in_no[2] = 8'd12;
        tick();
        req = '0;
        for (int c = 0; c < 4; c++) begin
            n_cmp++; if (cno !== 8'd10 || csrc !== 2'd0) begin n_mis++; $display("FAIL stall_hold%0d got no %0d src %0d exp 10 0", c, cno, csrc); end
            n_cmp++; if (committed !== 3'b000) begin n_mis++; $display("FAIL stall_nopulse%0d got %b exp 000", c, committed); end
            if (c < 3) tick();
        end
        ack = 1'b1;
        run_rotation("stall");
`ifdef COMMIT_ARB_STAT_EN
        n_cmp++; if (stall_cnt !== 16'd3) begin n_mis++; $display("FAIL stat_stall got %0d exp 3", stall_cnt); end
        n_cmp++; if (grant_cnt !== {16'd1, 16'd1, 16'd1}) begin n_mis++; $display("FAIL stat_grant got %h exp 000100010001", grant_cnt); end
`endif
    endtask

    task automatic test_priority_lock();
        do_reset();
        ack = 1'b1; req = 3'b001; in_no[0] = 8'd1;
        tick();
        req = '0;
        tick();
        ack = 1'b0; req = 3'b101; in_no[0] = 8'd20; in_no[2] = 8'd22;
        tick();
        n_cmp++; if (csrc !== 2'd2 || cno !== 8'd22) begin n_mis++; $display("FAIL prio_first got src %0d no %0d exp 2 22", csrc, cno); end
        req = 3'b010; in_no[1] = 8'd21;
        tick();
        req = '0;
        n_cmp++; if (csrc !== 2'd2 || cno !== 8'd22) begin n_mis++; $display("FAIL prio_lock got src %0d no %0d exp 2 22", csrc, cno); end
        ack = 1'b1;
        tick();
        n_cmp++; if (committed !== 3'b100) begin n_mis++; $display("FAIL prio_pulse2 got %b exp 100", committed); end
        n_cmp++; if (csrc !== 2'd0 || cno !== 8'd20) begin n_mis++; $display("FAIL prio_second got src %0d no %0d exp 0 20", csrc, cno); end
        tick();
        n_cmp++; if (committed !== 3'b001) begin n_mis++; $display("FAIL prio_pulse0 got %b exp 001", committed); end
        n_cmp++; if (csrc !== 2'd1 || cno !== 8'd21) begin n_mis++; $display("FAIL prio_third got src %0d no %0d exp 1 21", csrc, cno); end
        tick();
        n_cmp++; if (committed !== 3'b010) begin n_mis++; $display("FAIL prio_pulse1 got %b exp 010", committed); end
    endtask

    task automatic test_illegal();
        do_reset();
        ack = 1'b0; req = 3'b010; in_no[1] = 8'd7;
        tick();
        n_cmp++; if (busy !== 3'b010 || err !== 1'b0) begin n_mis++; $display("FAIL ill_pre got busy %b err %b exp 010 0", busy, err); end
        in_no[1] = 8'd9;
        tick();
        req = '0;
        n_cmp++; if (err !== 1'b1) begin n_mis++; $display("FAIL ill_err got %b exp 1", err); end
        n_cmp++; if (cno !== 8'd7) begin n_mis++; $display("FAIL ill_no got %0d exp 7", cno); end
        ack = 1'b1;
        tick();
        n_cmp++; if (committed !== 3'b010) begin n_mis++; $display("FAIL ill_pulse got %b exp 010", committed); end
        tick();
        n_cmp++; if (err !== 1'b1) begin n_mis++; $display("FAIL ill_sticky got %b exp 1", err); end
        do_reset();
        n_cmp++; if (err !== 1'b0) begin n_mis++; $display("FAIL ill_clear got %b exp 0", err); end
        ack = 1'b1; req = 3'b001; in_no[0] = 8'd3;
        tick();
        in_no[0] = 8'd4;
        tick();
        req = '0;
        n_cmp++; if (committed !== 3'b001) begin n_mis++; $display("FAIL race_pulse got %b exp 001", committed); end
        n_cmp++; if (busy !== 3'b000 || valid !== 1'b0) begin n_mis++; $display("FAIL race_dropped got busy %b valid %b exp 000 0", busy, valid); end
        n_cmp++; if (err !== 1'b1) begin n_mis++; $display("FAIL race_err got %b exp 1", err); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        ack = 1'b0; req = 3'b011; in_no[0] = 8'd30; in_no[1] = 8'd31;
        tick();
        req = '0;
        n_cmp++; if (busy !== 3'b011) begin n_mis++; $display("FAIL mid_busy got %b exp 011", busy); end
        reset = 1'b1; ack = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++; if (valid !== 1'b0 || busy !== 3'b000) begin n_mis++; $display("FAIL mid_clear got valid %b busy %b exp 0 000", valid, busy); end
        tick();
        n_cmp++; if (committed !== 3'b000) begin n_mis++; $display("FAIL mid_nopulse got %b exp 000", committed); end
`ifdef COMMIT_ARB_STAT_EN
        n_cmp++; if (grant_cnt !== '0 || stall_cnt !== '0) begin n_mis++; $display("FAIL mid_stat got %h %h exp 0 0", grant_cnt, stall_cnt); end
`endif
        ack = 1'b0;
    endtask

    initial begin
        reset = 1'b1; req = '0; ack = 1'b0; in_no = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_priority_lock();
        test_illegal();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/commit_arbiter_s.md
Name: commit_arbiter_s

Overview:
- Sits between the three scalar-unit execution sources (LdSt-1, LdSt-2, Math) and the scalar reorder buffer.
- Captures each source's commit request and issue number in a one-entry holding slot.
- Presents one commit per cycle to the reorder buffer using a round-robin valid/ack handshake.
- Returns a one-cycle committed pulse to the source that won, so the reorder buffer never sees more than one commit number per cycle.

Parameters:
- N_SRC, 3, number of commit sources (index 0 = LdSt-1, 1 = LdSt-2, 2 = Math).
- WIDTH_SRC, $clog2(N_SRC), width of the source index.
- WIDTH_CNT, 16, width of each statistics counter; used only with the optional feature.

Ports:
- clock  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- I_Req  in  N_SRC  per-source commit request; single-cycle pulse.
- I_No  in  N_SRC x issue_no_t  per-source issue number; sampled when I_Req[i]=1.
- O_Busy  out  N_SRC  holding slot i is occupied; source must not pulse I_Req[i] while this is high.
- O_Commit_Valid  out  1  a commit is presented to the reorder buffer.
- O_Commit_No  out  issue_no_t  issue number being presented.
- O_Commit_Src  out  WIDTH_SRC  index of the presented source.
- I_Commit_Ack  in  1  reorder buffer accepts the presented commit this cycle.
- O_Committed  out  N_SRC  one-cycle pulse to the source whose commit was accepted.
- O_Err  out  1  sticky flag: a request arrived while its slot was busy.

Behaviour:
- State per slot i: Pend[i] (EMPTY/PENDING) and No[i]. Arbiter state: RR pointer Last (index of last winner).
- Reset values:
  - Pend = 0, No = 0, Last = N_SRC-1, so source 0 has first priority.
  - O_Committed = 0, O_Err = 0.
  - As a consequence: O_Busy = 0, O_Commit_Valid = 0, O_Commit_No = 0, O_Commit_Src = 0.
- Capture:
  - I_Req[i] at edge t with Pend[i]=0 sets Pend[i]=1 and No[i]=I_No[i].
  - O_Busy[i] = Pend[i], registered. It is visible from cycle t+1.
- Selection (combinational from registered state):
  - Win = first i with Pend[i]=1, searching Last+1, Last+2, ... modulo N_SRC.
  - O_Commit_Valid = |Pend.
  - O_Commit_No = No[Win], O_Commit_Src = Win.
  - When nothing is pending, O_Commit_No and O_Commit_Src are 0.
- Handshake:
  - Fire = O_Commit_Valid & I_Commit_Ack.
  - On Fire: Pend[Win] clears, Last <= Win, and O_Committed[Win] = 1 in the next cycle (registered, one cycle wide).
  - Without Ack, the presented entry and Win stay stable; the arbiter does not switch to another source while valid and unacknowledged.
  - I_Commit_Ack while O_Commit_Valid=0 is ignored.
- Latency:
  - Minimum request-to-present is 1 cycle.
  - Minimum request-to-O_Committed is 2 cycles (request at t, ack at t+1, pulse at t+2).
- Throughput: one commit per cycle. Each source can sustain one commit per 2 cycles, because O_Busy drops the cycle after Fire.
- Simultaneous events:
  - I_Req[i] on the same edge that Pend[i] clears by Fire: O_Busy[i] was 1, so this is an illegal request. It is dropped and O_Err is set.
  - I_Req[i] and I_Req[j] on the same edge: both are captured.
  - All slots pending and Ack held high: grants rotate 0,1,2,0,... starting after Last.
- Illegal request (I_Req[i]=1 while Pend[i]=1): No[i] is unchanged, O_Err <= 1. Only reset clears O_Err.
- Reset mid-operation: all pending commits are discarded. No O_Committed pulse is produced for them.

Optional Feature:
- Macro: COMMIT_ARB_STAT_EN.
- Defined:
  - Adds an output O_Grant_Cnt, N_SRC x WIDTH_CNT.
  - Counter i increments on each Fire with Win=i, saturates at all-ones, and resets to 0.
  - Adds an output O_Stall_Cnt, WIDTH_CNT: increments each cycle with O_Commit_Valid=1 and I_Commit_Ack=0, and saturates.
- Undefined: both ports and all counter logic are absent. Core behaviour is identical.

Decomposition:
- pkg_tpu holds issue_no_t (existing) plus the new constants N_COMMIT_SRC=3 and COMMIT_SRC_LDST1/LDST2/MATH indices.
- One sub-module, rr_arbiter: a parameterised round-robin picker (request vector and Last in; one-hot and index out).
- The holding slots and handshake stay in commit_arbiter_s.

Test Plan:
- Reset, then I_Req[0] with I_No[0]=5, Ack tied 1: O_Commit_Valid=1 with No=5 and Src=0 in the next cycle; O_Committed=3'b001 one cycle later; O_Busy[0] clears the cycle after the accept (the cycle of the pulse).
- I_Req=3'b111 with No 10/11/12 on one edge, Ack=1: presents 10, 11, 12 on consecutive cycles; O_Committed pulses 001, 010, 100.
- Same as the previous scenario but Ack=0 for 4 cycles: O_Commit_No holds 10 and Src holds 0 for all 4 cycles, with no pulses; after Ack rises, normal rotation resumes.
- With Last=0 after a grant, pend sources 0 and 2: source 2 wins first, then source 0.
- I_Req[1] pulsed again while O_Busy[1]=1 with a different No: the original No is still committed and O_Err=1 sticks until reset.
- Reset asserted while 2 slots are pending: O_Commit_Valid=0 and O_Busy=0 the next cycle, with no O_Committed pulses. With COMMIT_ARB_STAT_EN defined, all counters read 0.
